// File: rtl/pe_multimode.sv
// pe_multimode: systolic MAC cell with a banked stationary weight, WS/OS modes,
// optional saturation with sticky flags, and an OS result drain chain.
module pe_multimode #(
  parameter int I_D_SIZE  = 16,
  parameter int F_D_SIZE  = 16,
  parameter int T_D_SIZE  = 37,
  parameter int NUM_BANKS = 4,
  parameter bit SATURATE  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk_en,
  input  logic                         mode_i,
  input  logic [I_D_SIZE-1:0]          input_i,
  input  logic                         input_valid_i,
  input  logic                         input_last_i,
  output logic [I_D_SIZE-1:0]          input_o,
  output logic                         input_valid_o,
  output logic                         input_last_o,
  input  logic [F_D_SIZE-1:0]          filter_i,
  input  logic                         filter_we,
  input  logic [$clog2(NUM_BANKS)-1:0] filter_waddr,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_sel_i,
  output logic [F_D_SIZE-1:0]          filter_o,
  input  logic [T_D_SIZE-1:0]          sum_i,
  input  logic                         sum_valid_i,
  output logic [T_D_SIZE-1:0]          sum_o,
  output logic                         sum_valid_o,
  output logic                         ovf_o,
  output logic                         collision_o
);
  localparam int P  = I_D_SIZE + F_D_SIZE;
  localparam int T1 = T_D_SIZE + 1;
  localparam logic signed [T_D_SIZE-1:0] SMIN = {1'b1, {(T_D_SIZE-1){1'b0}}};
  localparam logic signed [T_D_SIZE-1:0] SMAX = ~SMIN;

  logic signed [F_D_SIZE-1:0] bank_q [NUM_BANKS];
  logic                       mode_q, sum_valid_q, ovf_q, coll_q, in_valid_q, in_last_q;
  logic        [I_D_SIZE-1:0] in_q;
  logic        [F_D_SIZE-1:0] filt_q;
  logic signed [T_D_SIZE-1:0] acc_q, acc_d, sum_q, sum_d;
  logic                       sum_valid_d, ovf_d, coll_d;

  logic                       change, own, ovf_add;
  logic signed [F_D_SIZE-1:0] w;
  logic signed [P-1:0]        prod;
  logic signed [T_D_SIZE-1:0] prod_x, addend, res;
  logic signed [T_D_SIZE:0]   sum_x;

  // The beat in a mode-change cycle already runs in the new mode, on a cleared accumulator
  always_comb begin
    change      = mode_i != mode_q;
    own         = mode_i & input_valid_i & input_last_i;
    w           = mode_i ? $signed(filter_i) : bank_q[bank_sel_i];
    prod        = P'($signed(input_i)) * P'(w);
    prod_x      = T_D_SIZE'(prod);
    addend      = !mode_i ? $signed(sum_i) : (change ? '0 : acc_q);
    sum_x       = T1'(addend) + T1'(prod_x);
    ovf_add     = sum_x[T_D_SIZE] ^ sum_x[T_D_SIZE-1];
    res         = (SATURATE && ovf_add) ? (sum_x[T_D_SIZE] ? SMIN : SMAX) : sum_x[T_D_SIZE-1:0];
    acc_d       = (mode_i & input_valid_i & !input_last_i) ? res : ((own | change) ? '0 : acc_q);
    sum_d       = !mode_i ? (input_valid_i ? res : sum_q)
                          : (own ? res : (sum_valid_i ? $signed(sum_i) : sum_q));
    sum_valid_d = !change & (mode_i ? (own | sum_valid_i) : input_valid_i);
    ovf_d       = (!change & ovf_q) | (input_valid_i & ovf_add);
    coll_d      = (!change & coll_q) | (own & sum_valid_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= '0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      coll_q      <= 1'b0;
      in_q        <= '0;
      in_valid_q  <= 1'b0;
      in_last_q   <= 1'b0;
      filt_q      <= '0;
    end else if (clk_en) begin
      if (filter_we) bank_q[filter_waddr] <= filter_i;
      mode_q      <= mode_i;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      ovf_q       <= ovf_d;
      coll_q      <= coll_d;
      in_q        <= input_i;
      in_valid_q  <= input_valid_i;
      in_last_q   <= input_last_i;
      filt_q      <= filter_i;
    end
  end

  assign input_o       = in_q;
  assign input_valid_o = in_valid_q;
  assign input_last_o  = in_last_q;
  assign filter_o      = filt_q;
  assign sum_o         = sum_q;
  assign sum_valid_o   = sum_valid_q;
  assign ovf_o         = ovf_q;
  assign collision_o   = coll_q;
endmodule

// File: tb/tb_pe_multimode.sv
// tb_pe_multimode: directed and randomized checks of pe_multimode against an
// arithmetic reference model of the cell.
module tb_pe_multimode;
  localparam int I = 16, F = 16, T = 37, NB = 4;
  localparam bit SAT = 1;
  localparam longint MAXV = (longint'(1) <<< (T-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (T-1));

  logic clk = 0, rst_n = 0, clk_en = 1, mode_i = 0;
  logic [I-1:0] input_i = '0;
  logic input_valid_i = 0, input_last_i = 0, filter_we = 0, sum_valid_i = 0;
  logic [F-1:0] filter_i = '0;
  logic [1:0] filter_waddr = '0, bank_sel_i = '0;
  logic [T-1:0] sum_i = '0;
  logic [I-1:0] input_o;
  logic input_valid_o, input_last_o, sum_valid_o, ovf_o, collision_o;
  logic [F-1:0] filter_o;
  logic [T-1:0] sum_o;

  pe_multimode #(.I_D_SIZE(I), .F_D_SIZE(F), .T_D_SIZE(T), .NUM_BANKS(NB), .SATURATE(SAT)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mode_i(mode_i),
    .input_i(input_i), .input_valid_i(input_valid_i), .input_last_i(input_last_i),
    .input_o(input_o), .input_valid_o(input_valid_o), .input_last_o(input_last_o),
    .filter_i(filter_i), .filter_we(filter_we), .filter_waddr(filter_waddr),
    .bank_sel_i(bank_sel_i), .filter_o(filter_o),
    .sum_i(sum_i), .sum_valid_i(sum_valid_i), .sum_o(sum_o), .sum_valid_o(sum_valid_o),
    .ovf_o(ovf_o), .collision_o(collision_o)
  );

  always #5 clk = ~clk;

  longint m_bank [NB];
  longint m_acc, m_sum;
  bit m_mode, m_sv, m_ovf, m_coll, m_inv, m_inl;
  logic [I-1:0] m_in;
  logic [F-1:0] m_filt;
  int n_cmp = 0, n_err = 0;
  bit chk_on = 0;

  function automatic longint sat_add(input longint a, input longint b, output bit o);
    longint f, r;
    f = a + b;
    o = (f > MAXV) || (f < MINV);
    if (!o) return f;
    r = f & ((longint'(1) <<< T) - 1);
    if (r > MAXV) r = r - (longint'(1) <<< T);
    return SAT ? ((f > MAXV) ? MAXV : MINV) : r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) m_bank[b] = 0;
    m_acc = 0; m_sum = 0; m_mode = 0; m_sv = 0; m_ovf = 0; m_coll = 0;
    m_inv = 0; m_inl = 0; m_in = '0; m_filt = '0;
  endtask

  task automatic model_step();
    longint w, p, r;
    bit o, chg, own;
    if (!clk_en) return;
    chg = mode_i != m_mode;
    m_mode = mode_i;
    if (chg) begin m_acc = 0; m_ovf = 0; m_coll = 0; end
    w = mode_i ? longint'($signed(filter_i)) : m_bank[bank_sel_i];
    p = longint'($signed(input_i)) * w;
    own = mode_i && input_valid_i && input_last_i;
    if (!mode_i) begin
      if (input_valid_i) begin
        m_sum = sat_add(longint'($signed(sum_i)), p, o);
        m_ovf = m_ovf | o;
      end
      m_sv = input_valid_i;
    end else begin
      if (input_valid_i) begin
        r = sat_add(m_acc, p, o);
        m_ovf = m_ovf | o;
        if (input_last_i) begin m_sum = r; m_acc = 0; end
        else m_acc = r;
      end
      if (!own && sum_valid_i) m_sum = longint'($signed(sum_i));
      if (own && sum_valid_i) m_coll = 1;
      m_sv = own || sum_valid_i;
    end
    if (chg) m_sv = 0;
    if (filter_we) m_bank[filter_waddr] = longint'($signed(filter_i));
    m_in = input_i; m_inv = input_valid_i; m_inl = input_last_i; m_filt = filter_i;
  endtask

  task automatic cmp(input string nm, input longint act, input longint ex);
    n_cmp++;
    if (act != ex) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, ex, $time);
    end
  endtask

  always @(negedge clk) if (chk_on) begin
    cmp("sum_o", longint'($signed(sum_o)), m_sum);
    cmp("sum_valid_o", longint'(sum_valid_o), longint'(m_sv));
    cmp("ovf_o", longint'(ovf_o), longint'(m_ovf));
    cmp("collision_o", longint'(collision_o), longint'(m_coll));
    cmp("input_o", longint'(input_o), longint'(m_in));
    cmp("input_valid_o", longint'(input_valid_o), longint'(m_inv));
    cmp("input_last_o", longint'(input_last_o), longint'(m_inl));
    cmp("filter_o", longint'(filter_o), longint'(m_filt));
  end

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic drive(input int a, input int f, input bit v, input bit l);
    input_i = 16'(a); filter_i = 16'(f); input_valid_i = v; input_last_i = l;
    step();
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  function automatic longint sv_o();
    return longint'($signed(sum_o));
  endfunction

  initial begin
    bit chg;
    int pick;
    model_reset();
    chk_on = 1;
    @(posedge clk); #1;
    cmp("rst_sum", sv_o(), 0);
    cmp("rst_valid", longint'(sum_valid_o), 0);
    rst_n = 1;
    // WS basic
    filter_we = 1; filter_waddr = 2; drive(0, 3, 0, 0);
    filter_we = 0; bank_sel_i = 2; sum_i = 37'd10; drive(5, 0, 1, 0);
    cmp("ws_sum", sv_o(), 25);
    cmp("ws_valid", longint'(sum_valid_o), 1);
    drive(0, 0, 0, 0);
    cmp("ws_hold_sum", sv_o(), 25);
    cmp("ws_hold_valid", longint'(sum_valid_o), 0);
    // bank write/read hazard
    filter_we = 1; filter_waddr = 1; sum_i = '0; drive(0, 4, 0, 0);
    bank_sel_i = 1; drive(2, 7, 1, 0);
    cmp("hazard_old", sv_o(), 8);
    filter_we = 0; drive(2, 0, 1, 0);
    cmp("hazard_new", sv_o(), 14);
    // OS accumulation, back-to-back
    mode_i = 1; drive(0, 0, 0, 0);
    drive(1, 2, 1, 0); drive(3, 4, 1, 0);
    cmp("os_no_valid", longint'(sum_valid_o), 0);
    drive(5, 6, 1, 1);
    cmp("os_sum", sv_o(), 44);
    cmp("os_valid", longint'(sum_valid_o), 1);
    drive(1, 1, 1, 0);
    cmp("os_pulse", longint'(sum_valid_o), 0);
    drive(1, 1, 1, 0); drive(1, 1, 1, 1);
    cmp("os_sum2", sv_o(), 3);
    cmp("os_valid2", longint'(sum_valid_o), 1);
    // saturation
    mode_i = 0; filter_we = 1; filter_waddr = 0; drive(0, 1, 0, 0);
    filter_we = 0; bank_sel_i = 0; sum_i = 37'(MAXV); drive(1, 0, 1, 0);
    cmp("sat_sum", sv_o(), (longint'(1) <<< 36) - 1);
    cmp("sat_ovf", longint'(ovf_o), 1);
    drive(0, 0, 0, 0);
    cmp("sat_ovf_sticky", longint'(ovf_o), 1);
    // collision
    mode_i = 1; sum_i = '0; drive(0, 0, 0, 0);
    cmp("mode_clr_ovf", longint'(ovf_o), 0);
    drive(2, 3, 1, 0);
    sum_valid_i = 1; sum_i = 37'd99; drive(4, 5, 1, 1);
    cmp("coll_sum", sv_o(), 26);
    cmp("coll_flag", longint'(collision_o), 1);
    drive(0, 0, 0, 0);
    cmp("drain_sum", sv_o(), 99);
    cmp("drain_valid", longint'(sum_valid_o), 1);
    // clk_en freeze mid-sum, then mode toggle
    drive(2, 2, 1, 0);
    clk_en = 0; sum_valid_i = 0;
    for (int k = 0; k < 3; k++) begin
      mode_i = k[0]; drive(9, 9, 1, 1);
      cmp("frz_sum", sv_o(), 99);
      cmp("frz_valid", longint'(sum_valid_o), 1);
    end
    clk_en = 1; mode_i = 1; drive(1, 1, 1, 1);
    cmp("frz_resume", sv_o(), 5);
    drive(3, 3, 1, 0);
    mode_i = 0; drive(0, 0, 0, 0);
    cmp("tog_coll", longint'(collision_o), 0);
    cmp("tog_valid", longint'(sum_valid_o), 0);
    mode_i = 1; drive(0, 0, 0, 0);
    drive(1, 1, 1, 1);
    cmp("tog_acc_clr", sv_o(), 1);
    // reset mid-accumulation
    drive(7, 7, 1, 0);
    do_reset();
    cmp("mid_rst_sum", sv_o(), 0);
    drive(0, 0, 0, 0);
    drive(2, 2, 1, 1);
    cmp("post_rst_sum", sv_o(), 4);
    // randomized
    for (int n = 0; n < 4000; n++) begin
      clk_en = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 39) == 0) mode_i = ~mode_i;
      chg = mode_i != m_mode;
      input_i = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 40) - 20);
      filter_i = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 40) - 20);
      input_valid_i = ($urandom_range(0, 3) != 0) && !chg;
      input_last_i = $urandom_range(0, 3) == 0;
      sum_valid_i = ($urandom_range(0, 2) == 0) && !chg;
      filter_we = $urandom_range(0, 3) == 0;
      filter_waddr = 2'($urandom);
      bank_sel_i = 2'($urandom);
      pick = $urandom_range(0, 3);
      sum_i = (pick == 0) ? 37'(MAXV - longint'($urandom_range(0, 3))) :
              (pick == 1) ? 37'(MINV + longint'($urandom_range(0, 3))) :
                            37'({$urandom, $urandom});
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end
    @(posedge clk); #1;
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pe_multimode.md
# pe_multimode

Parametrised successor to the single weight-stationary MAC processing engine. It keeps a bank of NUM_BANKS stationary weights and can run in two modes: weight-stationary (WS), with the partial sum flowing through, or output-stationary (OS), with weights streamed and the sum accumulated locally. It adds valid qualification, optional saturation with sticky flags, and a drain chain for OS results. It is one cell of the CNN systolic array and chains horizontally (input/filter) and vertically (sum).

## Interface
Parameters:
- I_D_SIZE, 16, signed input activation width
- F_D_SIZE, 16, signed filter width
- T_D_SIZE, 37, signed partial-sum/accumulator width; must be ≥ I_D_SIZE+F_D_SIZE
- NUM_BANKS, 4, stationary weight registers; power of two, ≥2
- SATURATE, 1, 1 = saturating add, 0 = two's-complement wrap

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  global enable; low freezes all state, including bank writes
- mode_i  in  1  0 = WS, 1 = OS
- input_i  in  I_D_SIZE  activation
- input_valid_i  in  1  activation/filter beat valid
- input_last_i  in  1  OS: final beat of the current dot product
- input_o  out  I_D_SIZE  registered activation to the right neighbour
- input_valid_o  out  1  registered input_valid_i
- input_last_o  out  1  registered input_last_i
- filter_i  in  F_D_SIZE  WS: bank write data; OS: streamed weight
- filter_we  in  1  bank write strobe
- filter_waddr  in  $clog2(NUM_BANKS)  bank write address
- bank_sel_i  in  $clog2(NUM_BANKS)  WS weight bank select
- filter_o  out  F_D_SIZE  OS: registered filter_i to the neighbour
- sum_i  in  T_D_SIZE  WS: upstream partial sum; OS: drained result from upstream
- sum_valid_i  in  1  OS drain valid; ignored in WS
- sum_o  out  T_D_SIZE  result
- sum_valid_o  out  1  sum_o valid
- ovf_o  out  1  sticky saturation/overflow flag
- collision_o  out  1  sticky OS drain-collision flag

## Operation
- Reset drives all outputs, bank registers, the accumulator and the mode register to 0.
- Bank write:
  - On clk_en & filter_we, bank[filter_waddr] <= filter_i. This applies in both modes.
  - A same-cycle read of the written bank returns the old value.
- Product is $signed(input_i) * $signed(weight), width I+F, sign-extended to T_D_SIZE.
  - WS weight is bank[bank_sel_i].
  - OS weight is filter_i.
- Add rule:
  - SATURATE=1: clamp to [-2^(T-1), 2^(T-1)-1] on signed overflow and set ovf_o.
  - SATURATE=0: result wraps; ovf_o is still set on overflow.
- The input_o, input_valid_o, input_last_o and filter_o pipeline registers load every clk_en cycle regardless of mode.
- WS mode:
  - When input_valid_i: sum_o <= sum_i + product, sum_valid_o <= 1.
  - Otherwise sum_o holds and sum_valid_o <= 0.
- OS mode, local accumulator acc:
  - On a valid beat without last: acc <= acc + product.
  - On a valid beat with last: sum_o <= acc + product, sum_valid_o <= 1, acc <= 0 (starts the next dot product).
  - With no own result: if sum_valid_i then sum_o <= sum_i and sum_valid_o <= 1 (drain pass-through), else sum_valid_o <= 0.
  - If the own result and sum_valid_i occur in the same cycle, the own result wins, the upstream value is dropped, and collision_o sets.
- Mode register:
  - Samples mode_i every clk_en cycle.
  - Any change clears acc and sum_valid_o on that edge.
  - The beat presented in the change cycle is processed in the new mode.
- ovf_o and collision_o clear only on reset or on a mode change.

## Timing
- Latency is 1 clk_en cycle for every registered output. No combinational input-to-output paths.
- WS throughput: 1 MAC per cycle.
- OS result for an N-beat dot product: sum_valid_o is asserted the cycle after the beat carrying input_last_i.
- Back-to-back dot products (last followed immediately by a valid beat) run without bubbles.
- clk_en low holds all state and outputs; valid flags also hold.
- Reset asserted mid-accumulation clears everything asynchronously. After release, the first valid beat starts a fresh sum.

## Test plan
- Reset, then WS: write bank2=3 and select bank2; input 5, sum_i 10, valid → next cycle sum_o=25, sum_valid_o=1. A valid-low cycle then gives sum_valid_o=0 with sum_o held at 25.
- Bank write/read hazard: bank1=4, then in the same cycle write bank1=7 while reading bank1 with input 2 → sum_o=8. The next beat with input 2 → sum_o=14.
- OS accumulation: beats (1,2), (3,4), (5,6), the last one with input_last_i → single sum_valid_o pulse, sum_o=44. Three further beats (1,1) with last → sum_o=3 with no gap.
- Saturation (T_D_SIZE=37, SATURATE=1): WS with sum_i=2^36-1, input 1, weight 1 → sum_o=2^36-1, ovf_o=1 and staying 1.
- OS collision: own last beat coincides with sum_valid_i=1, sum_i=99 → sum_o is the own result and collision_o=1. A standalone sum_valid_i with sum_i=99 → sum_o=99.
- clk_en low for 3 cycles mid-OS-sum, plus a mode toggle → outputs frozen while low. After the toggle, acc and the sticky flags are 0.
